// File: rtl/priority_encoder.sv
// priority_encoder: LSB-first priority encoder (log-depth merge tree) with registered copy.
// Optional PRIORITY_ENCODER_ONEHOT_EN adds isolated-lowest-bit outputs onehot_o / onehot_q_o.
module priority_encoder #(
    parameter int NUM_WIRE = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_WIRE-1:0]         wire_in,
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    output logic [NUM_WIRE-1:0]         onehot_o,
    output logic [NUM_WIRE-1:0]         onehot_q_o,
`endif
    output logic [$clog2(NUM_WIRE)-1:0] index_o,
    output logic                        index_valid_o,
    output logic [$clog2(NUM_WIRE)-1:0] index_q_o,
    output logic                        index_valid_q_o
);
    localparam int W = $clog2(NUM_WIRE);
    localparam int P = 1 << W;

    if (NUM_WIRE < 2) begin : g_bad_width
        $error("priority_encoder: NUM_WIRE must be >= 2");
    end

    logic [P-1:0]   padded;
    logic [2*P-1:1] v;
    logic [W-1:0]   ix [2*P-1:1];

    assign padded = P'(wire_in);

    // Heap layout: leaves at P+i, node n merges 2n (lower indices) and 2n+1.
    // Invalid nodes carry index 0 so the all-zero case resolves to 0.
    genvar i;
    for (i = 0; i < P; i++) begin : g_leaf
        assign v[P+i]  = padded[i];
        assign ix[P+i] = padded[i] ? W'(i) : '0;
    end
    for (i = 1; i < P; i++) begin : g_node
        assign v[i]  = v[2*i] | v[2*i+1];
        assign ix[i] = v[2*i] ? ix[2*i] : ix[2*i+1];
    end

    assign index_o       = ix[1];
    assign index_valid_o = v[1];

`ifdef PRIORITY_ENCODER_ONEHOT_EN
    assign onehot_o = wire_in & (~wire_in + NUM_WIRE'(1));
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index_q_o       <= '0;
            index_valid_q_o <= 1'b0;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
            onehot_q_o      <= '0;
`endif
        end else begin
            index_q_o       <= index_o;
            index_valid_q_o <= index_valid_o;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
            onehot_q_o      <= onehot_o;
`endif
        end
    end
endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: randomized self-checking bench against a lowest-set-bit reference model.
module tb_priority_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] w   = '0;
    logic [3:0]  idx, idx_q;
    logic        vld, vld_q;
    logic [4:0]  w5  = '0;
    logic [2:0]  idx5, idx5_q;
    logic        vld5, vld5_q;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
    logic [15:0] oh, oh_q;
    logic [4:0]  oh5, oh5_q;
`endif
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    priority_encoder #(.NUM_WIRE(16)) dut (
        .clk_i(clk), .rst_i(rst), .wire_in(w),
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        .onehot_o(oh), .onehot_q_o(oh_q),
`endif
        .index_o(idx), .index_valid_o(vld), .index_q_o(idx_q), .index_valid_q_o(vld_q)
    );

    priority_encoder #(.NUM_WIRE(5)) dut5 (
        .clk_i(clk), .rst_i(rst), .wire_in(w5),
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        .onehot_o(oh5), .onehot_q_o(oh5_q),
`endif
        .index_o(idx5), .index_valid_o(vld5), .index_q_o(idx5_q), .index_valid_q_o(vld5_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [15:0] v);
        for (int k = 0; k < 16; k++)
            if (v[k]) return k;
        return 0;
    endfunction

    // Drive a vector, check the combinational result, then the registered copy after the edge.
    task automatic apply(input string tag, input logic [15:0] v);
        int          e_idx;
        logic        e_vld;
        logic [15:0] e_oh;
        e_idx = lowest(v);
        e_vld = (v != 0);
        e_oh  = e_vld ? (16'd1 << e_idx) : 16'd0;
        @(negedge clk);
        w = v;
        #1;
        check({tag, ".idx"}, 32'(idx), 32'(e_idx));
        check({tag, ".vld"}, 32'(vld), 32'(e_vld));
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        check({tag, ".oh"}, 32'(oh), 32'(e_oh));
`endif
        @(posedge clk);
        #1;
        check({tag, ".idx_q"}, 32'(idx_q), 32'(e_idx));
        check({tag, ".vld_q"}, 32'(vld_q), 32'(e_vld));
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        check({tag, ".oh_q"}, 32'(oh_q), 32'(e_oh));
`endif
    endtask

    initial begin
        @(posedge clk);
        #1;
        check("reset.idx_q", 32'(idx_q), 32'd0);
        check("reset.vld_q", 32'(vld_q), 32'd0);
        check("reset.idx5_q", 32'(idx5_q), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        apply("zero", 16'h0000);
        apply("prio_f0a8", 16'hF0A8);
        apply("all_ones", 16'hFFFF);
        apply("msb_only", 16'h8000);
        for (int k = 0; k < 16; k++)
            apply($sformatf("walk%0d", k), 16'd1 << k);

        for (int n = 0; n < 1000; n++) begin
            logic [15:0] r;
            case ($urandom_range(0, 3))
                0:       r = 16'd1 << $urandom_range(0, 15);
                1:       r = 16'($urandom) & 16'($urandom) & 16'($urandom) & 16'hFF00;
                default: r = 16'($urandom);
            endcase
            if ($urandom_range(0, 49) == 0) r = '0;
            apply("rand", r);
        end

        apply("pre_reset", 16'h0010);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst.idx_q", 32'(idx_q), 32'd0);
        check("rst.vld_q", 32'(vld_q), 32'd0);
        check("rst.idx_comb", 32'(idx), 32'd4);
        check("rst.vld_comb", 32'(vld), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst.idx_q", 32'(idx_q), 32'd4);
        check("post_rst.vld_q", 32'(vld_q), 32'd1);

        @(negedge clk);
        w5 = 5'b10000;
        #1;
        check("n5.msb.idx", 32'(idx5), 32'd4);
        check("n5.msb.vld", 32'(vld5), 32'd1);
        @(posedge clk);
        #1;
        check("n5.msb.idx_q", 32'(idx5_q), 32'd4);
        @(negedge clk);
        w5 = 5'b10110;
        #1;
        check("n5.mix.idx", 32'(idx5), 32'd1);
`ifdef PRIORITY_ENCODER_ONEHOT_EN
        check("n5.mix.oh", 32'(oh5), 32'b00010);
        @(posedge clk);
        #1;
        check("n5.mix.oh_q", 32'(oh5_q), 32'b00010);
`endif
        @(negedge clk);
        w5 = 5'b00000;
        #1;
        check("n5.zero.idx", 32'(idx5), 32'd0);
        check("n5.zero.vld", 32'(vld5), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
